regfile_2r1w: RTL and testbench

- 32-entry by 64-bit register file for the pipelined CPU's decode stage.
- Two combinational read ports and one synchronous write port.
- Consumes the bit-level 4:1 selection primitives: read muxing is built as 32:1 trees of 4:1 muxes, one tree per data bit per port.
- Register 31 is hardwired to zero (XZR); writes to it are discarded.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_2r1w_prims.sv | 74 +++++++
 rtl/regfile_2r1w.sv | 71 +++++++
 tb/tb_regfile_2r1w.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 32 x 64 decode-stage register file.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/regfile_2r1w_prims.sv
// Building blocks for the register file: enable register, write decoder and
// the per-bit 32:1 read tree made of 4:1 muxes.
module reg_en #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb data_d = en_i ? d_i : data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

module decoder5_32
  import regfile_pkg::*;
(
  input  regaddr_t            addr_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = en_i;
  end

endmodule

module mux4_1 (
  input  logic [3:0] d_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);

  assign y_o = d_i[sel_i];

endmodule

module mux32_1
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] d_i,
  input  regaddr_t            sel_i,
  output logic                y_o
);

  logic [7:0] lvl1;
  logic [1:0] lvl2;

  // Two 4:1 levels narrow 32 inputs to two, the top address bit picks the last.
  for (genvar g = 0; g < 8; g++) begin : gLvl1
    mux4_1 uMux (.d_i(d_i[4*g +: 4]), .sel_i(sel_i[1:0]), .y_o(lvl1[g]));
  end

  for (genvar g = 0; g < 2; g++) begin : gLvl2
    mux4_1 uMux (.d_i(lvl1[4*g +: 4]), .sel_i(sel_i[3:2]), .y_o(lvl2[g]));
  end

  assign y_o = sel_i[4] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with a hardwired-zero entry and an optional
// same-cycle write-to-read bypass.
module regfile_2r1w #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import regfile_pkg::*;

  logic [NUM_REGS-1:0] wrEn;
  logic [DATA_W-1:0]   regQ   [NUM_REGS];
  logic [NUM_REGS-1:0] bitCol [DATA_W];
  logic [DATA_W-1:0]   muxOut1;
  logic [DATA_W-1:0]   muxOut2;
  logic                hit1;
  logic                hit2;

  decoder5_32 uDec (.addr_i(WriteRegister), .en_i(RegWrite), .onehot_o(wrEn));

  // The zero entry has no storage; its decoder output only qualifies the bypass.
  for (genvar r = 0; r < NUM_REGS; r++) begin : gRegs
    if (r == ZERO_REG) begin : gZero
      assign regQ[r] = '0;
    end else begin : gStore
      reg_en #(.W(DATA_W)) uReg (
        .clk  (clk),
        .reset(reset),
        .en_i (wrEn[r]),
        .d_i  (WriteData),
        .q_o  (regQ[r])
      );
    end
  end

  always_comb begin
    for (int b = 0; b < DATA_W; b++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bitCol[b][r] = regQ[r][b];
      end
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : gBits
    mux32_1 uMux1 (.d_i(bitCol[b]), .sel_i(ReadRegister1), .y_o(muxOut1[b]));
    mux32_1 uMux2 (.d_i(bitCol[b]), .sel_i(ReadRegister2), .y_o(muxOut2[b]));
  end

  // Forward the in-flight write so a same-cycle read sees the new value.
  always_comb begin
    hit1 = (BYPASS != 0) && RegWrite && !reset && !wrEn[ZERO_REG]
           && (WriteRegister == ReadRegister1);
    hit2 = (BYPASS != 0) && RegWrite && !reset && !wrEn[ZERO_REG]
           && (WriteRegister == ReadRegister2);
  end

  assign ReadData1 = hit1 ? WriteData : muxOut1;
  assign ReadData2 = hit2 ? WriteData : muxOut2;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed and random steps compared
// against an array model of the register file.
`timescale 1ns/1ps
module tb_regfile_2r1w;

  localparam int Bypass = 1;
  localparam logic [63:0] SweepBase = 64'h0123_4567_89AB_0000;

  logic        clk;
  logic        reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  bit          clkRun;
  logic [63:0] model [32];
  int          vectors;
  int          miscompares;

  regfile_2r1w #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(Bypass)) dut (
    .clk          (clk),
    .reset        (reset),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] expRead(input logic [4:0] a);
    if (reset) return '0;
    if (a == 5'd31) return '0;
    if (Bypass != 0 && RegWrite && WriteRegister == a) return WriteData;
    return model[a];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic checkOutput(input string tag);
    logic [63:0] e1;
    logic [63:0] e2;
    e1 = expRead(ReadRegister1);
    e2 = expRead(ReadRegister2);
    vectors += 2;
    assert (ReadData1 === e1) else begin
      miscompares++;
      $error("[TB] FAIL %s rd1 addr=%0d observed=%h expected=%h", tag, ReadRegister1, ReadData1, e1);
    end
    assert (ReadData2 === e2) else begin
      miscompares++;
      $error("[TB] FAIL %s rd2 addr=%0d observed=%h expected=%h", tag, ReadRegister2, ReadData2, e2);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                               input logic [63:0] d, input logic we);
    if (clkRun) @(negedge clk);
    else #5;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    WriteRegister = w;
    WriteData     = d;
    RegWrite      = we;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    if (RegWrite && !reset && WriteRegister != 5'd31) model[WriteRegister] = WriteData;
    #1;
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'd0, 64'd0, 1'b0);
      checkOutput(tag);
    end
  endtask

  initial begin
    logic [4:0]  r1, r2, w;
    logic [63:0] d;
    logic        we;

    clk = 0; clkRun = 0; reset = 0;
    ReadRegister1 = 0; ReadRegister2 = 0; WriteRegister = 0; WriteData = 0; RegWrite = 0;
    vectors = 0; miscompares = 0;

    // Reset pulse with the clock stopped
    #3 reset = 1;
    resetModel();
    #2;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(i), 5'd0, 64'd0, 1'b0);
      checkOutput("reset_hold");
    end
    reset = 0;
    #2 checkOutput("reset_release");
    clkRun = 1;

    // Write sweep of 0..30, then read every index back
    for (int i = 0; i < 31; i++) begin
      applyStimulus(5'(i), 5'(i), 5'(i), SweepBase + 64'(i), 1'b1);
      checkOutput("sweep_bypass");
      stepEdge();
    end
    readAll("sweep_readback");

    // Writes to the zero register are discarded
    applyStimulus(5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    checkOutput("zero_pre_edge");
    stepEdge();
    checkOutput("zero_post_edge");
    readAll("zero_others_kept");

    // Write enable low for three cycles
    applyStimulus(5'd5, 5'd5, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
    repeat (3) begin
      stepEdge();
      checkOutput("wr_disable");
    end
    vectors++;
    assert (ReadData1 === 64'h0123_4567_89AB_0005) else begin
      miscompares++;
      $error("[TB] FAIL wr_disable_const observed=%h expected=%h", ReadData1, 64'h0123_4567_89AB_0005);
    end

    // Same-cycle bypass on both ports, then the zero-register variant
    applyStimulus(5'd7, 5'd7, 5'd7, 64'hA5A5_5A5A_A5A5_5A5A, 1'b1);
    checkOutput("bypass_pre_edge");
    stepEdge();
    checkOutput("bypass_post_edge");
    applyStimulus(5'd31, 5'd31, 5'd31, 64'hA5A5_5A5A_A5A5_5A5A, 1'b1);
    checkOutput("bypass_zero_pre");
    stepEdge();
    checkOutput("bypass_zero_post");

    // Random traffic, biased toward read-after-write address matches
    repeat (300) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      w  = 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r1 = w;
      if ($urandom_range(0, 3) == 0) r2 = w;
      applyStimulus(r1, r2, w, d, we);
      checkOutput("random_pre_edge");
      stepEdge();
      checkOutput("random_post_edge");
    end
    readAll("random_readback");

    // Asynchronous reset between edges while a write is pending
    applyStimulus(5'd10, 5'd3, 5'd10, 64'h5555_AAAA_5555_AAAA, 1'b1);
    checkOutput("async_setup");
    stepEdge();
    #1 reset = 1;
    resetModel();
    #1 checkOutput("async_pre_edge");
    stepEdge();
    checkOutput("async_post_edge");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'd10, 64'h5555_AAAA_5555_AAAA, 1'b1);
      checkOutput("async_hold");
    end
    @(negedge clk);
    reset = 0;
    WriteRegister = 5'd3; WriteData = 64'h1; RegWrite = 1'b1;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd4;
    #1 checkOutput("post_reset_bypass");
    stepEdge();
    checkOutput("post_reset_write");
    readAll("post_reset_readback");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
